// File: rtl/store_forward_buffer.sv
// Program-ordered store buffer: speculative/committed regions, in-order drain to
// the data cache, and byte-granular store-to-load forwarding across live entries.
module store_forward_buffer #(
    parameter int ENTRIES      = 8,
    parameter int COMMIT_PORTS = 2,
    parameter int ROB_W        = 5,
    parameter int ADDR_W       = 30
) (
    input  logic                    cpu_clk_i,
    input  logic                    cpu_rst_ni,
    input  logic                    flush_i,
    input  logic                    enq_valid_i,
    input  logic [ADDR_W-1:0]       enq_addr_i,
    input  logic [31:0]             enq_data_i,
    input  logic [3:0]              enq_bm_i,
    input  logic                    enq_io_i,
    input  logic [ROB_W-1:0]        enq_rob_i,
    output logic                    enq_full_o,
    output logic                    cmp_valid_o,
    output logic [ROB_W-1:0]        cmp_rob_o,
    input  logic [COMMIT_PORTS-1:0] commit_i,
    input  logic [ADDR_W-1:0]       fwd_addr_i,
    input  logic [3:0]              fwd_bm_i,
    output logic [31:0]             fwd_data_o,
    output logic [3:0]              fwd_bm_o,
    output logic                    fwd_hit_o,
    output logic                    fwd_resolvable_o,
    output logic                    drain_valid_o,
    output logic [ADDR_W-1:0]       drain_addr_o,
    output logic [31:0]             drain_data_o,
    output logic [3:0]              drain_bm_o,
    output logic                    drain_io_o,
    input  logic                    drain_done_i,
    output logic                    empty_o
);
    localparam int IW = $clog2(ENTRIES);
    localparam int PW = IW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        bm;
        logic              io;
    } entry_t;

    entry_t            mem [ENTRIES];
    logic [PW-1:0]     head, cptr, tail, count, n_commit;
    logic              accept, pop;

    // Extra pointer MSB separates a full ring from an empty one.
    assign count       = tail - head;
    assign enq_full_o  = (count == PW'(ENTRIES));
    assign empty_o     = (head == tail);
    assign accept      = enq_valid_i & ~enq_full_o & ~flush_i;
    assign drain_valid_o = (head != cptr);
    assign pop         = drain_done_i & drain_valid_o;

    always_comb begin
        n_commit = '0;
        for (int k = 0; k < COMMIT_PORTS; k++)
            n_commit = n_commit + PW'(commit_i[k]);
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            head <= '0;
            cptr <= '0;
            tail <= '0;
        end else begin
            head <= head + PW'(pop);
            cptr <= cptr + n_commit;
            if (flush_i)     tail <= cptr + n_commit;
            else if (accept) tail <= tail + PW'(1);
        end
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (accept) begin
            mem[tail[IW-1:0]] <= '{addr: enq_addr_i, data: enq_data_i, bm: enq_bm_i, io: enq_io_i};
        end
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            cmp_valid_o <= 1'b0;
            cmp_rob_o   <= '0;
        end else begin
            cmp_valid_o <= accept;
            if (accept) cmp_rob_o <= enq_rob_i;
        end
    end

    entry_t head_e;
    assign head_e       = mem[head[IW-1:0]];
    assign drain_addr_o = drain_valid_o ? head_e.addr : '0;
    assign drain_data_o = drain_valid_o ? head_e.data : '0;
    assign drain_bm_o   = drain_valid_o ? head_e.bm   : '0;
    assign drain_io_o   = drain_valid_o & head_e.io;

    // Per-age view of the ring: age 0 is the oldest live entry.
    logic [ENTRIES-1:0][IW-1:0] slot;
    logic [ENTRIES-1:0]         live, match, ovl, io_vec;

    for (genvar k = 0; k < ENTRIES; k++) begin : g_age
        assign slot[k]   = head[IW-1:0] + IW'(k);
        assign live[k]   = PW'(k) < count;
        assign match[k]  = live[k] & (mem[slot[k]].addr == fwd_addr_i);
        assign ovl[k]    = match[k] & (|(mem[slot[k]].bm & fwd_bm_i));
        assign io_vec[k] = mem[slot[k]].io;
    end

    // Walk oldest to youngest so younger bytes overwrite older ones.
    always_comb begin
        fwd_data_o = '0;
        fwd_bm_o   = '0;
        for (int k = 0; k < ENTRIES; k++)
            for (int b = 0; b < 4; b++)
                if (match[k] && !mem[slot[k]].io && mem[slot[k]].bm[b]) begin
                    fwd_data_o[8*b +: 8] = mem[slot[k]].data[8*b +: 8];
                    fwd_bm_o[b]          = 1'b1;
                end
    end

    assign fwd_hit_o        = |ovl;
    assign fwd_resolvable_o = fwd_hit_o & ~(|(ovl & io_vec)) & ((fwd_bm_i & ~fwd_bm_o) == 4'b0);

endmodule

// File: tb/tb_store_forward_buffer.sv
// Directed bench for store_forward_buffer: queue-based reference model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_store_forward_buffer;
    localparam int E  = 4;
    localparam int CP = 2;
    localparam int RW = 5;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i, enq_valid_i, enq_io_i, drain_done_i;
    logic [AW-1:0] enq_addr_i, fwd_addr_i;
    logic [31:0]   enq_data_i;
    logic [3:0]    enq_bm_i, fwd_bm_i;
    logic [RW-1:0] enq_rob_i;
    logic [CP-1:0] commit_i;
    logic          enq_full_o, cmp_valid_o, fwd_hit_o, fwd_resolvable_o;
    logic          drain_valid_o, drain_io_o, empty_o;
    logic [RW-1:0] cmp_rob_o;
    logic [31:0]   fwd_data_o, drain_data_o;
    logic [3:0]    fwd_bm_o, drain_bm_o;
    logic [AW-1:0] drain_addr_o;

    always #5 clk = ~clk;

    store_forward_buffer #(.ENTRIES(E), .COMMIT_PORTS(CP), .ROB_W(RW), .ADDR_W(AW)) dut (
        .cpu_clk_i(clk), .cpu_rst_ni(rst_n), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_addr_i(enq_addr_i), .enq_data_i(enq_data_i),
        .enq_bm_i(enq_bm_i), .enq_io_i(enq_io_i), .enq_rob_i(enq_rob_i),
        .enq_full_o(enq_full_o), .cmp_valid_o(cmp_valid_o), .cmp_rob_o(cmp_rob_o),
        .commit_i(commit_i), .fwd_addr_i(fwd_addr_i), .fwd_bm_i(fwd_bm_i),
        .fwd_data_o(fwd_data_o), .fwd_bm_o(fwd_bm_o), .fwd_hit_o(fwd_hit_o),
        .fwd_resolvable_o(fwd_resolvable_o), .drain_valid_o(drain_valid_o),
        .drain_addr_o(drain_addr_o), .drain_data_o(drain_data_o), .drain_bm_o(drain_bm_o),
        .drain_io_o(drain_io_o), .drain_done_i(drain_done_i), .empty_o(empty_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    bm;
        logic          io;
    } ent_t;

    ent_t          q[$];
    int            ncom = 0;
    logic          exp_cv = 1'b0;
    logic [RW-1:0] exp_rob = '0;
    bit            en = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: program-ordered queue, first ncom entries committed.
    task automatic model_step();
        int   n;
        bit   acc, pp;
        ent_t e;
        n   = $countones(commit_i);
        acc = enq_valid_i && (q.size() < E) && !flush_i;
        pp  = drain_done_i && (ncom > 0);
        if (n > q.size() - ncom) begin
            vectors++;
            miscompares++;
            $display("FAIL commit_overrun: commit %0d with %0d speculative", n, q.size() - ncom);
        end
        if (pp) begin
            void'(q.pop_front());
            ncom--;
        end
        ncom += n;
        if (flush_i)
            while (q.size() > ncom) void'(q.pop_back());
        if (acc) begin
            e.addr = enq_addr_i; e.data = enq_data_i; e.bm = enq_bm_i; e.io = enq_io_i;
            q.push_back(e);
        end
        exp_cv = acc;
        if (acc) exp_rob = enq_rob_i;
    endtask

    always @(negedge clk) begin : compare_p
        logic [31:0] d;
        logic [3:0]  m;
        bit          hit, io;
        if (en) begin
            d = '0; m = '0; hit = 0; io = 0;
            foreach (q[i]) begin
                if (q[i].addr == fwd_addr_i) begin
                    if ((q[i].bm & fwd_bm_i) != 4'b0) begin
                        hit = 1;
                        if (q[i].io) io = 1;
                    end
                    if (!q[i].io)
                        for (int b = 0; b < 4; b++)
                            if (q[i].bm[b]) begin
                                d[8*b +: 8] = q[i].data[8*b +: 8];
                                m[b] = 1'b1;
                            end
                end
            end
            chk("m_full", enq_full_o, q.size() == E);
            chk("m_empty", empty_o, q.size() == 0);
            chk("m_cmp_valid", cmp_valid_o, exp_cv);
            if (exp_cv) chk("m_cmp_rob", cmp_rob_o, exp_rob);
            chk("m_drain_valid", drain_valid_o, ncom > 0);
            if (ncom > 0) begin
                chk("m_drain_addr", drain_addr_o, q[0].addr);
                chk("m_drain_data", drain_data_o, q[0].data);
                chk("m_drain_bm", drain_bm_o, q[0].bm);
                chk("m_drain_io", drain_io_o, q[0].io);
            end
            chk("m_fwd_data", fwd_data_o, d);
            chk("m_fwd_bm", fwd_bm_o, m);
            chk("m_fwd_hit", fwd_hit_o, hit);
            chk("m_fwd_res", fwd_resolvable_o, !io && hit && ((fwd_bm_i & ~m) == 4'b0));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (en) model_step();
        #1;
    endtask

    task automatic set_enq(input logic [AW-1:0] a, input logic [31:0] dt, input logic [3:0] bm,
                           input logic io, input logic [RW-1:0] rob);
        enq_valid_i = 1'b1; enq_addr_i = a; enq_data_i = dt;
        enq_bm_i = bm; enq_io_i = io; enq_rob_i = rob;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush_i = 0; enq_valid_i = 0; enq_io_i = 0; drain_done_i = 0;
        enq_addr_i = '0; enq_data_i = '0; enq_bm_i = '0; enq_rob_i = '0; commit_i = '0;
        fwd_addr_i = '0; fwd_bm_i = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty_o, 1); chk("rst_full", enq_full_o, 0);
        chk("rst_drain_valid", drain_valid_o, 0); chk("rst_cmp_valid", cmp_valid_o, 0);
        chk("rst_cmp_rob", cmp_rob_o, 0); chk("rst_fwd_hit", fwd_hit_o, 0);
        chk("rst_fwd_data", fwd_data_o, 0); chk("rst_fwd_res", fwd_resolvable_o, 0);
        @(posedge clk); #1; rst_n = 1'b1; en = 1'b1;

        // Fill to capacity, then a refused fifth store.
        for (int i = 1; i <= 4; i++) begin
            set_enq(30'h100 + 30'(i), 32'h1000_0000 + 32'(i), 4'hF, 1'b0, RW'(i));
            tick();
            @(negedge clk);
            chk("fill_cmp_valid", cmp_valid_o, 1); chk("fill_cmp_rob", cmp_rob_o, i);
        end
        chk("fill_full", enq_full_o, 1);
        set_enq(30'h105, 32'h1000_0005, 4'hF, 1'b0, 5'd5);
        tick(); enq_valid_i = 0;
        @(negedge clk);
        chk("refuse_cmp_valid", cmp_valid_o, 0); chk("refuse_full", enq_full_o, 1);

        // Commit two, flush the other two, drain in order.
        commit_i = 2'b11; tick(); commit_i = '0; flush_i = 1; tick(); flush_i = 0;
        @(negedge clk);
        chk("flush_full", enq_full_o, 0); chk("flush_drain_valid", drain_valid_o, 1);
        chk("flush_drain_data1", drain_data_o, 32'h1000_0001);
        tick(); tick();
        @(negedge clk);
        chk("drain_hold", drain_data_o, 32'h1000_0001);
        drain_done_i = 1; tick();
        @(negedge clk);
        chk("flush_drain_data2", drain_data_o, 32'h1000_0002);
        tick(); drain_done_i = 0;
        @(negedge clk);
        chk("flush_empty", empty_o, 1); chk("flush_drain_off", drain_valid_o, 0);

        // Forwarding merge, youngest wins per byte.
        set_enq(30'h10, 32'h1122_3344, 4'hF, 1'b0, 5'd6); tick();
        set_enq(30'h10, 32'hAABB_CCDD, 4'h3, 1'b0, 5'd7); tick(); enq_valid_i = 0;
        fwd_addr_i = 30'h10; fwd_bm_i = 4'hF;
        @(negedge clk);
        chk("merge_data", fwd_data_o, 32'h1122_CCDD); chk("merge_bm", fwd_bm_o, 4'hF);
        chk("merge_res", fwd_resolvable_o, 1); chk("merge_hit", fwd_hit_o, 1);
        fwd_addr_i = 30'h11; fwd_bm_i = 4'h4; tick();
        @(negedge clk);
        chk("miss_hit", fwd_hit_o, 0); chk("miss_data", fwd_data_o, 0);
        commit_i = 2'b11; fwd_addr_i = 30'h10; fwd_bm_i = 4'hF; tick();
        commit_i = '0; drain_done_i = 1; tick(); drain_done_i = 0;
        @(negedge clk);
        chk("partial_bm", fwd_bm_o, 4'h3); chk("partial_data", fwd_data_o, 32'h0000_CCDD);
        chk("partial_res", fwd_resolvable_o, 0); chk("partial_hit", fwd_hit_o, 1);
        drain_done_i = 1; tick(); drain_done_i = 0;
        @(negedge clk);
        chk("merge_empty", empty_o, 1);

        // Flush with a simultaneous single commit keeps exactly one entry.
        for (int i = 8; i <= 10; i++) begin
            set_enq(30'h30 + 30'(i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0, RW'(i));
            tick();
        end
        enq_valid_i = 0; commit_i = 2'b01; flush_i = 1; tick(); commit_i = '0; flush_i = 0;
        @(negedge clk);
        chk("fc_drain_valid", drain_valid_o, 1); chk("fc_drain_addr", drain_addr_o, 30'h38);
        chk("fc_empty", empty_o, 0);
        drain_done_i = 1; tick(); drain_done_i = 0;
        @(negedge clk);
        chk("fc_empty_after", empty_o, 1);

        // I/O store blocks forwarding.
        fwd_addr_i = 30'h20; fwd_bm_i = 4'h1;
        set_enq(30'h20, 32'h0000_0055, 4'h1, 1'b1, 5'd11); tick(); enq_valid_i = 0;
        @(negedge clk);
        chk("io_hit", fwd_hit_o, 1); chk("io_res", fwd_resolvable_o, 0);
        chk("io_bm", fwd_bm_o, 0); chk("io_data", fwd_data_o, 0);
        commit_i = 2'b01; tick(); commit_i = '0;
        @(negedge clk);
        chk("io_drain_io", drain_io_o, 1);
        drain_done_i = 1; tick(); drain_done_i = 0;

        // Full with a same-cycle pop still refuses the enqueue.
        set_enq(30'h41, 32'h4100_0000, 4'hF, 1'b0, 5'd12); tick();
        for (int i = 13; i <= 15; i++) begin
            set_enq(30'h30 + 30'(i), 32'h4100_0000 + 32'(i), 4'hF, 1'b0, RW'(i));
            commit_i = 2'b01; tick();
        end
        set_enq(30'h50, 32'h5000_0016, 4'h6, 1'b0, 5'd16); commit_i = 2'b01; drain_done_i = 1;
        tick();
        @(negedge clk);
        chk("fullpop_cmp_valid", cmp_valid_o, 0); chk("fullpop_full", enq_full_o, 0);
        commit_i = '0; tick();
        @(negedge clk);
        chk("after_cmp_valid", cmp_valid_o, 1); chk("after_cmp_rob", cmp_rob_o, 16);
        enq_valid_i = 0; commit_i = 2'b01; tick(); commit_i = '0;
        for (int k = 0; k < 8 && !empty_o; k++) tick();
        drain_done_i = 0;
        @(negedge clk);
        chk("fullpop_empty", empty_o, 1);

        // Enqueue, commit, pop and flush in one cycle.
        set_enq(30'h61, 32'h6100_0017, 4'hF, 1'b0, 5'd17); tick();
        set_enq(30'h62, 32'h6200_0018, 4'hF, 1'b0, 5'd18); commit_i = 2'b01; tick();
        set_enq(30'h63, 32'h6300_0019, 4'hF, 1'b0, 5'd19); drain_done_i = 1; flush_i = 1;
        tick(); enq_valid_i = 0; commit_i = '0; drain_done_i = 0; flush_i = 0;
        @(negedge clk);
        chk("all_cmp_valid", cmp_valid_o, 0); chk("all_drain_addr", drain_addr_o, 30'h62);
        chk("all_empty", empty_o, 0);
        drain_done_i = 1; tick(); drain_done_i = 0;
        @(negedge clk);
        chk("all_empty_after", empty_o, 1);

        // Reset mid-operation clears committed entries too.
        set_enq(30'h70, 32'h7000_0020, 4'hF, 1'b0, 5'd20); tick();
        set_enq(30'h71, 32'h7100_0021, 4'hF, 1'b0, 5'd21); commit_i = 2'b01; tick();
        enq_valid_i = 0; commit_i = '0;
        en = 1'b0; rst_n = 1'b0; q.delete(); ncom = 0; exp_cv = 1'b0;
        #1;
        chk("mrst_empty", empty_o, 1); chk("mrst_drain_valid", drain_valid_o, 0);
        chk("mrst_cmp_valid", cmp_valid_o, 0); chk("mrst_full", enq_full_o, 0);
        @(posedge clk); #1; rst_n = 1'b1; en = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/store_forward_buffer.md
# store_forward_buffer

Parametrised store buffer for the memory system. It sits between the AGU store enqueue path and the data-cache store port, and is the successor to the fixed 8-entry, dual-commit store buffer. It holds stores in program order and splits them into a speculative region and a committed region; a configurable commit width moves stores from speculative to committed. Committed stores drain to the cache one at a time. Loads get byte-granular forwarding merged across all matching entries, oldest to youngest. A pipeline flush discards only speculative stores.

## Interface
- ENTRIES, 8, queue depth; power of two, at least 2.
- COMMIT_PORTS, 2, commit bits per cycle; 1 to 4.
- ROB_W, 5, ROB tag width.
- ADDR_W, 30, word-address width.

- cpu_clk_i  in  1  clock; all state updates on the rising edge.
- cpu_rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all speculative entries.
- enq_valid_i  in  1  store enqueue request.
- enq_addr_i  in  ADDR_W  store word address.
- enq_data_i  in  32  store data, byte-lane aligned.
- enq_bm_i  in  4  byte mask.
- enq_io_i  in  1  I/O (uncacheable) store.
- enq_rob_i  in  ROB_W  ROB tag of the store.
- enq_full_o  out  1  buffer full; enqueue refused.
- cmp_valid_o  out  1  store accepted last cycle (ROB completion).
- cmp_rob_o  out  ROB_W  tag of the completed store.
- commit_i  in  COMMIT_PORTS  thermometer commit count (bit k set implies bits below k are set).
- fwd_addr_i  in  ADDR_W  load word address.
- fwd_bm_i  in  4  load byte mask.
- fwd_data_o  out  32  forwarded bytes.
- fwd_bm_o  out  4  bytes supplied by the buffer.
- fwd_hit_o  out  1  some entry overlaps the load.
- fwd_resolvable_o  out  1  all requested bytes supplied and no I/O overlap.
- drain_valid_o  out  1  oldest committed store presented to the cache.
- drain_addr_o  out  ADDR_W  address of the presented store.
- drain_data_o  out  32  data of the presented store.
- drain_bm_o  out  4  byte mask of the presented store.
- drain_io_o  out  1  I/O flag of the presented store.
- drain_done_i  in  1  cache finished the presented store.
- empty_o  out  1  no entries held.

## Operation
- Storage is a circular array. It has three pointers, each log2(ENTRIES)+1 bits: head (oldest), cptr (first uncommitted entry) and tail (next free slot).
- Committed region is [head, cptr). Speculative region is [cptr, tail).
- Count = tail - head, modulo 2·ENTRIES. enq_full_o = (count == ENTRIES). empty_o = (head == tail).
- Accept condition: enq_valid_i & !enq_full_o & !flush_i. On accept, the entry is written at tail and tail increments. Next cycle, cmp_valid_o=1 and cmp_rob_o=enq_rob_i.
- Commit: n = popcount(commit_i); cptr += n. n never exceeds the speculative count; the bench asserts this.
- Flush: tail <= cptr + n. Commits in the flush cycle are honoured. Committed entries and any in-flight drain are untouched.
- Drain: drain_valid_o = (head != cptr). Drain fields come from entry[head] and are held stable until drain_done_i. On drain_done_i & drain_valid_o, head increments. drain_done_i without drain_valid_o is ignored.
- Forwarding is combinational over all valid entries [head, tail).
  - For each byte b, the youngest non-I/O entry with addr == fwd_addr_i and bm[b]=1 supplies data[b] and sets fwd_bm_o[b].
  - fwd_hit_o = some matching entry has (bm & fwd_bm_i) != 0.
  - An overlapping I/O entry forces fwd_resolvable_o=0.
  - Otherwise fwd_resolvable_o = ((fwd_bm_i & ~fwd_bm_o) == 0) & fwd_hit_o.
  - Bytes not supplied read 0.
- Pointer wrap: the index is the pointer's low bits; the MSB distinguishes full from empty.

## Timing
- Reset values: pointers 0, enq_full_o=0, empty_o=1, cmp_valid_o=0, cmp_rob_o=0, drain_valid_o=0, drain fields 0, forward outputs 0.
- An enqueue is visible to forwarding in the cycle after acceptance.
- Earliest drain: commit in cycle t+1 after acceptance in t, then drain_valid_o in t+2.
- enq_full_o derives from registered pointers only. A pop in the same cycle does not free a slot for an enqueue that cycle.
- Enqueue, commit, drain pop and flush may all occur in one cycle; each pointer update uses the rules above independently.
- Reset asserted mid-operation clears all entries at once, including committed ones.

## Test plan
- Reset with ENTRIES=4: expect empty_o=1, enq_full_o=0, drain_valid_o=0, cmp_valid_o=0.
- Enqueue ROB tags 1,2,3,4 on consecutive cycles: cmp_rob_o pulses 1..4, each one cycle later. enq_full_o=1 after the 4th. A 5th enqueue (tag 5) is refused and no cmp pulse follows.
- Forwarding merge: enqueue 0x10/0x11223344/bm F, then 0x10/0xAABBCCDD/bm 3. Query 0x10 bm F: expect fwd_data_o=0x1122CCDD, fwd_bm_o=F, fwd_resolvable_o=1.
- Flush: 4 entries, commit_i=2'b11, then flush_i. Expect count 2. Drain presents tags 1 and 2 in order, holding each until drain_done_i. empty_o=1 after two done pulses.
- Flush with simultaneous commit: 3 speculative entries, commit_i=2'b01 with flush_i. Expect 1 entry retained, which later drains.
- I/O: enqueue I/O store 0x20 bm 1. Query 0x20 bm 1: expect fwd_hit_o=1, fwd_resolvable_o=0, fwd_bm_o=0.
